// File: rtl/imem_loader_pkg.sv
// Shared types and sizing helpers for the byte-serial instruction-memory loader.
package imem_pkg;

    localparam int IMEM_ADDR_WIDTH = 10;
    localparam int IMEM_DATA_WIDTH = 40;
    localparam int PAD_BYTE_WIDTH  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CSUM,
        S_COMMIT
    } loader_state_t;

    // Number of pad bytes needed to carry a field of the given bit width.
    function automatic int byte_count(input int width);
        return (width + PAD_BYTE_WIDTH - 1) / PAD_BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Instruction-memory write port: one-cycle write strobe with address and data.
interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = IMEM_DATA_WIDTH
);

    logic                  imem_write;
    logic [ADDR_WIDTH-1:0] imem_write_adr;
    logic [DATA_WIDTH-1:0] imem_in;

    modport master (
        output imem_write,
        output imem_write_adr,
        output imem_in
    );

    modport slave (
        input imem_write,
        input imem_write_adr,
        input imem_in
    );

endinterface

// File: rtl/imem_loader_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pad level, with an optional
// registered rising-edge pulse output in place of the synchronised level.
module sync_edge #(
    parameter int STAGES = 2,
    parameter bit EDGE   = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] chain;

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_edge: STAGES must be at least 2");
    end

    // NOTE: non-blocking assignments make every stage capture its neighbour's
    // previous value; blocking ones would collapse the chain into a single flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
        end
    end

    if (EDGE) begin : g_edge
        logic level_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                level_q  <= 1'b0;
                sync_out <= 1'b0;
            end else begin
                level_q  <= chain[STAGES-1];
                sync_out <= chain[STAGES-1] & ~level_q;
            end
        end
    end else begin : g_level
        assign sync_out = chain[STAGES-1];
    end

endmodule

// File: rtl/imem_loader.sv
// Assembles MSB-first byte-serial pad frames (address, data, optional XOR
// checksum) into single instruction-memory writes, with auto-increment streaming.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH  = IMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = IMEM_DATA_WIDTH,
    parameter int BYTE_WIDTH  = PAD_BYTE_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int CHECKSUM    = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_en,
    input  logic                  byte_strobe,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    input  logic                  auto_inc_en,
    input  logic                  err_clear,
    imem_loader_if.master         imem,
    output logic                  busy,
    output logic                  err_sticky,
    output logic [15:0]           words_written
);

    localparam int         ADDR_BYTES = byte_count(ADDR_WIDTH);
    localparam int         DATA_BYTES = byte_count(DATA_WIDTH);
    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BYTES - 1);
    localparam logic [7:0] DATA_LAST  = 8'(DATA_BYTES - 1);

    if (BYTE_WIDTH != PAD_BYTE_WIDTH) begin : g_bad_byte_width
        $error("imem_loader: BYTE_WIDTH must be 8");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("imem_loader: SYNC_STAGES must be at least 2");
    end

    loader_state_t         state;
    logic                  load_en_s;
    logic                  strobe_rise;
    logic [BYTE_WIDTH-1:0] byte_s0;
    logic [BYTE_WIDTH-1:0] byte_q;
    logic [BYTE_WIDTH-1:0] csum;
    logic [BYTE_WIDTH-1:0] csum_next;
    logic [7:0]            byte_cnt;
    logic [ADDR_WIDTH-1:0] addr_sr;
    logic [ADDR_WIDTH-1:0] addr_shifted;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [DATA_WIDTH-1:0] data_sr;
    logic [DATA_WIDTH-1:0] data_shifted;
    logic                  have_addr;

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_load_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (load_en),
        .sync_out (load_en_s)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_strobe_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (byte_strobe),
        .sync_out (strobe_rise)
    );

    // The pad byte is stable for the whole strobe-high window, so a plain
    // two-flop capture is settled well before the edge pulse reaches the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_s0 <= '0;
            byte_q  <= '0;
        end else begin
            byte_s0 <= byte_in;
            byte_q  <= byte_s0;
        end
    end

    assign addr_shifted = ADDR_WIDTH'({addr_sr, byte_q});
    assign data_shifted = DATA_WIDTH'({data_sr, byte_q});
    assign csum_next    = csum ^ byte_q;
    assign addr_inc     = imem.imem_write_adr + ADDR_WIDTH'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= S_IDLE;
            busy                <= 1'b0;
            err_sticky          <= 1'b0;
            words_written       <= '0;
            byte_cnt            <= '0;
            csum                <= '0;
            addr_sr             <= '0;
            data_sr             <= '0;
            next_addr           <= '0;
            have_addr           <= 1'b0;
            imem.imem_write     <= 1'b0;
            imem.imem_write_adr <= '0;
            imem.imem_in        <= '0;
        end else begin
            imem.imem_write <= 1'b0;
            // NOTE: the clear is scheduled first so that an error raised further
            // down in the same cycle overrides it (the last non-blocking write wins).
            if (err_clear) begin
                err_sticky <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    byte_cnt <= '0;
                    csum     <= '0;
                    data_sr  <= '0;
                    if (!load_en_s) begin
                        have_addr <= 1'b0;
                    end else if (auto_inc_en && have_addr) begin
                        state   <= S_DATA;
                        busy    <= 1'b1;
                        addr_sr <= next_addr;
                    end else begin
                        state   <= S_ADDR;
                        busy    <= 1'b1;
                        addr_sr <= '0;
                    end
                end

                S_ADDR, S_DATA, S_CSUM: begin
                    if (!load_en_s) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        err_sticky <= 1'b1;
                        have_addr  <= 1'b0;
                    end else if (strobe_rise) begin
                        csum     <= csum_next;
                        byte_cnt <= byte_cnt + 8'd1;
                        if (state == S_ADDR) begin
                            addr_sr <= addr_shifted;
                            if (byte_cnt == ADDR_LAST) begin
                                state    <= S_DATA;
                                byte_cnt <= '0;
                            end
                        end else if (state == S_DATA) begin
                            data_sr <= data_shifted;
                            if (byte_cnt == DATA_LAST) begin
                                byte_cnt <= '0;
                                if (CHECKSUM != 0) begin
                                    state <= S_CSUM;
                                end else begin
                                    state               <= S_COMMIT;
                                    imem.imem_write     <= 1'b1;
                                    imem.imem_write_adr <= addr_sr;
                                    imem.imem_in        <= data_shifted;
                                end
                            end
                        end else if (csum_next == '0) begin
                            state               <= S_COMMIT;
                            imem.imem_write     <= 1'b1;
                            imem.imem_write_adr <= addr_sr;
                            imem.imem_in        <= data_sr;
                        end else begin
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            err_sticky <= 1'b1;
                        end
                    end
                end

                S_COMMIT: begin
                    words_written <= words_written + 16'd1;
                    have_addr     <= 1'b1;
                    next_addr     <= addr_inc;
                    byte_cnt      <= '0;
                    csum          <= '0;
                    data_sr       <= '0;
                    // A load_en fall seen here lets the write finish without an error.
                    if (!load_en_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (auto_inc_en) begin
                        state   <= S_DATA;
                        addr_sr <= addr_inc;
                    end else begin
                        state   <= S_ADDR;
                        addr_sr <= '0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default instance (10-bit address, 40-bit data,
// checksum) and a 12/16-bit instance without checksum, sharing the pad stimulus.
module tb_imem_loader;

    localparam int LATENCY = 2 + 2;

    logic       clk         = 1'b0;
    logic       reset_n     = 1'b1;
    logic       load_en     = 1'b0;
    logic       byte_strobe = 1'b0;
    logic [7:0] byte_in     = 8'h00;
    logic       auto_inc_en = 1'b0;
    logic       err_clear   = 1'b0;

    logic        busy_a, err_a, busy_b, err_b;
    logic [15:0] words_a, words_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    int wr_cnt_a = 0;
    int wr_cnt_b = 0;
    int wr_cyc_b = 0;
    int wr_base;

    logic [9:0]  last_adr_a  = '0;
    logic [39:0] last_data_a = '0;
    logic [11:0] last_adr_b  = '0;
    logic [15:0] last_data_b = '0;

    imem_loader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(40)) bus_a ();
    imem_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus_b ();

    imem_loader #(
        .ADDR_WIDTH(10), .DATA_WIDTH(40), .BYTE_WIDTH(8), .SYNC_STAGES(2), .CHECKSUM(1)
    ) dut_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_en       (load_en),
        .byte_strobe   (byte_strobe),
        .byte_in       (byte_in),
        .auto_inc_en   (auto_inc_en),
        .err_clear     (err_clear),
        .imem          (bus_a),
        .busy          (busy_a),
        .err_sticky    (err_a),
        .words_written (words_a)
    );

    imem_loader #(
        .ADDR_WIDTH(12), .DATA_WIDTH(16), .BYTE_WIDTH(8), .SYNC_STAGES(2), .CHECKSUM(0)
    ) dut_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_en       (load_en),
        .byte_strobe   (byte_strobe),
        .byte_in       (byte_in),
        .auto_inc_en   (auto_inc_en),
        .err_clear     (err_clear),
        .imem          (bus_b),
        .busy          (busy_b),
        .err_sticky    (err_b),
        .words_written (words_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: a pulse held for two cycles counts twice.
    always @(negedge clk) begin
        if (bus_a.imem_write === 1'b1) begin
            wr_cnt_a++;
            last_adr_a  = bus_a.imem_write_adr;
            last_data_a = bus_a.imem_in;
        end
        if (bus_b.imem_write === 1'b1) begin
            wr_cnt_b++;
            wr_cyc_b    = cyc;
            last_adr_b  = bus_b.imem_write_adr;
            last_data_b = bus_b.imem_in;
        end
    end

    // All tasks are entered just after a falling clock edge.
    task automatic begin_load();
        load_en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in     = b;
        byte_strobe = 1'b1;
        rise_cyc    = cyc;
        repeat (4) @(negedge clk);
        byte_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Last byte of a frame; load_en is released so its synchronised fall lands
    // in the commit cycle, which must not count as an abort.
    task automatic end_frame(input logic [7:0] b);
        byte_in     = b;
        byte_strobe = 1'b1;
        rise_cyc    = cyc;
        repeat (2) @(negedge clk);
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        byte_strobe = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_err_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus_a.imem_write !== 1'b0) begin failures++; $display("FAIL reset_write: got %b want 0", bus_a.imem_write); end
        checks++; if (bus_a.imem_write_adr !== 10'h000) begin failures++; $display("FAIL reset_adr: got %h want 000", bus_a.imem_write_adr); end
        checks++; if (bus_a.imem_in !== 40'h0) begin failures++; $display("FAIL reset_data: got %h want 0", bus_a.imem_in); end
        checks++; if ({busy_a, err_a} !== 2'b00) begin failures++; $display("FAIL reset_flags: got busy=%b err=%b want 0 0", busy_a, err_a); end
        checks++; if (words_a !== 16'h0000) begin failures++; $display("FAIL reset_words: got %h want 0000", words_a); end
        reset_n = 1'b1;
        @(negedge clk);
        wr_base = wr_cnt_a;
        begin_load();
        send_byte(8'h02);
        send_byte(8'hA5);
        send_byte(8'h11);
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL midframe_busy: got %b want 1", busy_a); end
        reset_n = 1'b0;
        #1;
        checks++; if ({busy_a, err_a, bus_a.imem_write} !== 3'b000) begin failures++; $display("FAIL async_reset: got busy=%b err=%b wr=%b want 0 0 0", busy_a, err_a, bus_a.imem_write); end
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (wr_cnt_a - wr_base !== 0) begin failures++; $display("FAIL reset_no_write: got %0d writes want 0", wr_cnt_a - wr_base); end
        checks++; if ({busy_a, err_a, words_a} !== 18'h0) begin failures++; $display("FAIL reset_release: got busy=%b err=%b words=%h want all 0", busy_a, err_a, words_a); end
    endtask

    task automatic test_frame();
        wr_base = wr_cnt_a;
        begin_load();
        send_byte(8'h02); send_byte(8'hA5);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        end_frame(8'hB6);  // 02^A5^11^22^33^44^55 = B6
        checks++; if (wr_cnt_a - wr_base !== 1) begin failures++; $display("FAIL frame_pulses: got %0d want 1", wr_cnt_a - wr_base); end
        checks++; if (last_adr_a !== 10'h2A5) begin failures++; $display("FAIL frame_adr: got %h want 2a5", last_adr_a); end
        checks++; if (last_data_a !== 40'h1122334455) begin failures++; $display("FAIL frame_data: got %h want 1122334455", last_data_a); end
        checks++; if (words_a !== 16'd1) begin failures++; $display("FAIL frame_words: got %0d want 1", words_a); end
        checks++; if ({busy_a, err_a} !== 2'b00) begin failures++; $display("FAIL frame_flags: got busy=%b err=%b want 0 0", busy_a, err_a); end
    endtask

    task automatic test_bad_checksum();
        wr_base = wr_cnt_a;
        begin_load();
        send_byte(8'h02); send_byte(8'hA5);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        end_frame(8'h00);
        checks++; if (wr_cnt_a - wr_base !== 0) begin failures++; $display("FAIL csum_no_write: got %0d writes want 0", wr_cnt_a - wr_base); end
        checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL csum_err: got %b want 1", err_a); end
        checks++; if (words_a !== 16'd1) begin failures++; $display("FAIL csum_words: got %0d want 1", words_a); end
        pulse_err_clear();
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL err_clear: got %b want 0", err_a); end
    endtask

    task automatic test_auto_inc();
        auto_inc_en = 1'b1;
        wr_base = wr_cnt_a;
        begin_load();
        send_byte(8'h03); send_byte(8'hFF);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
        send_byte(8'hFD);  // 03^FF^01^02^03^04^05 = FD
        checks++; if (wr_cnt_a - wr_base !== 1) begin failures++; $display("FAIL auto_first_pulses: got %0d want 1", wr_cnt_a - wr_base); end
        checks++; if (last_adr_a !== 10'h3FF) begin failures++; $display("FAIL auto_first_adr: got %h want 3ff", last_adr_a); end
        checks++; if (last_data_a !== 40'h0102030405) begin failures++; $display("FAIL auto_first_data: got %h want 0102030405", last_data_a); end
        send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D); send_byte(8'h0E);
        end_frame(8'h0E);  // 0A^0B^0C^0D^0E = 0E
        checks++; if (wr_cnt_a - wr_base !== 2) begin failures++; $display("FAIL auto_second_pulses: got %0d want 2", wr_cnt_a - wr_base); end
        checks++; if (last_adr_a !== 10'h000) begin failures++; $display("FAIL auto_wrap_adr: got %h want 000", last_adr_a); end
        checks++; if (last_data_a !== 40'h0A0B0C0D0E) begin failures++; $display("FAIL auto_second_data: got %h want 0a0b0c0d0e", last_data_a); end
        checks++; if ({err_a, words_a} !== {1'b0, 16'd3}) begin failures++; $display("FAIL auto_status: got err=%b words=%0d want 0 3", err_a, words_a); end
        auto_inc_en = 1'b0;
    endtask

    task automatic test_abort();
        wr_base = wr_cnt_a;
        begin_load();
        send_byte(8'h02); send_byte(8'hA5); send_byte(8'h11);
        load_en = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy_a); end
        checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL abort_err: got %b want 1", err_a); end
        checks++; if (wr_cnt_a - wr_base !== 0) begin failures++; $display("FAIL abort_no_write: got %0d writes want 0", wr_cnt_a - wr_base); end
        pulse_err_clear();
        begin_load();
        send_byte(8'h01); send_byte(8'h23);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
        end_frame(8'hCC);  // 01^23^AA^BB^CC^DD^EE = CC
        checks++; if (wr_cnt_a - wr_base !== 1) begin failures++; $display("FAIL recover_pulses: got %0d want 1", wr_cnt_a - wr_base); end
        checks++; if (last_adr_a !== 10'h123) begin failures++; $display("FAIL recover_adr: got %h want 123", last_adr_a); end
        checks++; if (last_data_a !== 40'hAABBCCDDEE) begin failures++; $display("FAIL recover_data: got %h want aabbccddee", last_data_a); end
        checks++; if ({err_a, words_a} !== {1'b0, 16'd4}) begin failures++; $display("FAIL recover_status: got err=%b words=%0d want 0 4", err_a, words_a); end
    endtask

    task automatic test_no_checksum();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wr_base = wr_cnt_b;
        begin_load();
        send_byte(8'h0F); send_byte(8'hFF); send_byte(8'hAB);
        end_frame(8'hCD);
        checks++; if (wr_cnt_b - wr_base !== 1) begin failures++; $display("FAIL nocsum_pulses: got %0d want 1", wr_cnt_b - wr_base); end
        checks++; if (last_adr_b !== 12'hFFF) begin failures++; $display("FAIL nocsum_adr: got %h want fff", last_adr_b); end
        checks++; if (last_data_b !== 16'hABCD) begin failures++; $display("FAIL nocsum_data: got %h want abcd", last_data_b); end
        checks++; if (wr_cyc_b - rise_cyc !== LATENCY) begin failures++; $display("FAIL nocsum_latency: got %0d cycles want %0d", wr_cyc_b - rise_cyc, LATENCY); end
        checks++; if ({err_b, busy_b, words_b} !== {2'b00, 16'd1}) begin failures++; $display("FAIL nocsum_status: got err=%b busy=%b words=%0d want 0 0 1", err_b, busy_b, words_b); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_frame();
        test_bad_checksum();
        test_auto_inc();
        test_abort();
        test_no_checksum();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
